pe_tree_ctrl: RTL and testbench

Frame-level scheduler for the 3x3 float16 convolution PE tree. Holds the F*F kernel weights loaded through a serial config port and issues a programmed number of input windows into the tree. Tracks the tree's fixed pipeline latency with a valid shift register and captures every result into an output FIFO with ready/valid backpressure. Credit-based issue means no result is ever dropped, even though the tree itself cannot stall.

---
 rtl/pe_tree_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pe_tree_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tree_ctrl.sv
// rtl/pe_tree_ctrl.sv - frame scheduler and result buffer for the FxF float16 PE tree
module pe_tree_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int F          = 3,
    parameter int PIPE_LAT   = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int NW_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [DATA_WIDTH-1:0]      cfg_data,
    input  logic                       start,
    input  logic [NW_WIDTH-1:0]        num_win,
    input  logic                       win_valid,
    output logic                       win_ready,
    input  logic [DATA_WIDTH*F*F-1:0]  win_data,
    output logic [DATA_WIDTH*F*F-1:0]  pe_param,
    output logic [DATA_WIDTH*F*F-1:0]  pe_data,
    input  logic [DATA_WIDTH-1:0]      pe_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int NUM_W = F * F;
    localparam int IDX_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] weights [NUM_W];
    logic [IDX_W-1:0]      wr_idx;
    logic                  params_ok;

    logic [NW_WIDTH-1:0]   num_lat;
    logic [NW_WIDTH-1:0]   issued;
    logic [OCC_W-1:0]      occ;

    logic [PIPE_LAT-1:0]   vld_sr;
    logic [PIPE_LAT-1:0]   vld_next;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      count;

    logic cfg_hs;
    logic start_ok;
    logic win_hs;
    logic push;
    logic pop;

    // Handshake qualifiers shared by the FSM and the datapath
    always_comb begin
        cfg_ready = (state == IDLE) && !rst;
        cfg_hs    = cfg_valid && cfg_ready;
        start_ok  = (state == IDLE) && start && params_ok
                    && (num_win != '0) && !cfg_hs;
        // occ is registered, so consumer backpressure never reaches win_ready combinationally
        win_ready = (state == RUN) && (issued < num_lat)
                    && (occ < OCC_W'(FIFO_DEPTH));
        win_hs    = win_valid && win_ready;
        push      = vld_sr[PIPE_LAT-1];
        res_valid = (count != '0);
        pop       = res_valid && res_ready;
        res_data  = res_valid ? fifo_mem[rd_ptr] : '0;
        busy      = (state != IDLE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and frame_done pulse
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (win_hs && ((issued + NW_WIDTH'(1)) == num_lat)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (occ == '0) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Serial weight load; rewriting slot 0 invalidates the set until all slots are refreshed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_W; i++) begin
                weights[i] <= '0;
            end
            wr_idx    <= '0;
            params_ok <= 1'b0;
        end else if (cfg_hs) begin
            weights[wr_idx] <= cfg_data;
            if (wr_idx == IDX_W'(NUM_W - 1)) begin
                wr_idx    <= '0;
                params_ok <= 1'b1;
            end else begin
                wr_idx <= wr_idx + IDX_W'(1);
                if (wr_idx == '0) begin
                    params_ok <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_W; i++) begin : g_param
        assign pe_param[i*DATA_WIDTH +: DATA_WIDTH] = weights[i];
    end

    // Frame window budget and issue count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_lat <= '0;
            issued  <= '0;
        end else if (start_ok) begin
            num_lat <= num_win;
            issued  <= '0;
        end else if (win_hs) begin
            issued <= issued + NW_WIDTH'(1);
        end
    end

    // Window register feeding the tree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_data <= '0;
        end else if (win_hs) begin
            pe_data <= win_data;
        end
    end

    // Next value of the latency tracker: shift up, new window enters at bit 0
    always_comb begin
        vld_next    = vld_sr << 1;
        vld_next[0] = win_hs;
    end

    // Valid shift register mirroring the tree pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= vld_next;
        end
    end

    // Credit count: windows in flight plus results waiting in the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= occ + {{(OCC_W-1){1'b0}}, win_hs} - {{(OCC_W-1){1'b0}}, pop};
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pe_result;
        end
    end

    // Result FIFO pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + {{(OCC_W-1){1'b0}}, push} - {{(OCC_W-1){1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_pe_tree_ctrl.sv
// tb/tb_pe_tree_ctrl.sv - self-checking bench for pe_tree_ctrl
module tb_pe_tree_ctrl;

    localparam int DW = 16;
    localparam int F  = 3;
    localparam int NW = F * F;
    localparam int PL = 6;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DW-1:0]     cfg_data;
    logic              start;
    logic [15:0]       num_win;
    logic              win_valid;
    logic              win_ready;
    logic [DW*NW-1:0]  win_data;
    logic [DW*NW-1:0]  pe_param;
    logic [DW*NW-1:0]  pe_data;
    logic [DW-1:0]     pe_result;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_data;
    logic              busy;
    logic              frame_done;

    pe_tree_ctrl #(
        .DATA_WIDTH(DW), .F(F), .PIPE_LAT(PL), .FIFO_DEPTH(FD), .NW_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .start(start), .num_win(num_win),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .pe_param(pe_param), .pe_data(pe_data), .pe_result(pe_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tag      = 1;

    logic [DW*NW-1:0] ones_w;
    logic [DW-1:0]    exp_q[$];
    int acc_count, pop_count, fd_count, max_occ;
    int first_acc, last_acc, first_pop, last_pop;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic real fp16_to_real(input logic [15:0] h);
        real v;
        int e;
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(int'(h[9:0])) / 1024.0;
        for (int k = 15; k < e; k++) v = v * 2.0;
        for (int k = e; k < 15; k++) v = v / 2.0;
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_fp16(input real x);
        real a;
        int e, m;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 15;
        while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        m = int'($floor((a - 1.0) * 1024.0));
        return {s, e[4:0], m[9:0]};
    endfunction

    // Ideal dot product of a window against a weight set
    function automatic logic [15:0] dot(input logic [DW*NW-1:0] x, input logic [DW*NW-1:0] w);
        real acc;
        acc = 0.0;
        for (int i = 0; i < NW; i++)
            acc = acc + fp16_to_real(x[i*DW +: DW]) * fp16_to_real(w[i*DW +: DW]);
        return real_to_fp16(acc);
    endfunction

    function automatic logic [DW*NW-1:0] make_win(input int t);
        logic [DW*NW-1:0] w;
        w = {NW{16'h3C00}};
        w[15:0] = real_to_fp16(real'(t));
        return w;
    endfunction

    // PE tree model: result of pe_data loaded at edge n is sampled at edge n+PL
    logic [DW-1:0] pipe [PL-1];
    always @(posedge clk) begin
        pipe[0] <= dot(pe_data, pe_param);
        for (int k = 1; k < PL - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign pe_result = pipe[PL-2];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: handshakes seen at negedge complete at the following posedge
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("sb_result", res_data, exp_q.pop_front());
                pop_count++;
                if (first_pop < 0) first_pop = cyc + 1;
                last_pop = cyc + 1;
            end
            if (win_valid && win_ready) begin
                exp_q.push_back(dot(win_data, ones_w));
                acc_count++;
                if (first_acc < 0) first_acc = cyc + 1;
                last_acc = cyc + 1;
                if (exp_q.size() > max_occ) max_occ = exp_q.size();
            end
            if (frame_done) fd_count++;
        end
    end

    task automatic clear_stats();
        acc_count = 0; pop_count = 0; fd_count = 0; max_occ = 0;
        first_acc = -1; last_acc = -1; first_pop = -1; last_pop = -1;
    endtask

    task automatic write_weights(input int n);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = 16'h3C00;
            @(negedge clk);
            check("cfg_ready", cfg_ready, 1);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic try_start(input logic [15:0] nw, input bit with_cfg);
        start     = 1'b1;
        num_win   = nw;
        cfg_valid = with_cfg;
        cfg_data  = 16'h3C00;
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic drive_frame(input int nw, input int hold, input bit rnd, input int budget,
                               output int acc_hold, output bit wr_hold, output bit done);
        int sent, cycles;
        bit hs;
        sent = 0; cycles = 0; done = 1'b0; acc_hold = 0; wr_hold = 1'b1;
        while (!done && cycles < budget) begin
            win_valid = (sent < nw);
            win_data  = make_win(tag);
            if (rnd) res_ready = 1'($urandom_range(0, 1));
            else     res_ready = (cycles >= hold);
            @(negedge clk);
            hs = win_valid && win_ready;
            if (frame_done) done = 1'b1;
            if (hold > 0 && cycles == hold - 1) begin
                acc_hold = sent;
                wr_hold  = win_ready;
            end
            @(posedge clk); #1;
            if (hs) begin sent++; tag++; end
            cycles++;
        end
        win_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    typedef struct {
        int          nload;
        logic [15:0] nw;
        bit          with_cfg;
        bit          exp_busy;
    } start_vec_t;

    start_vec_t tv [5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_edge, rv_cyc, acc_hold, n5;
        bit wr_hold, done, hs;

        tv[0] = '{nload: 5, nw: 16'd3, with_cfg: 1'b0, exp_busy: 1'b0};
        tv[1] = '{nload: 0, nw: 16'd0, with_cfg: 1'b0, exp_busy: 1'b0};
        tv[2] = '{nload: 4, nw: 16'd0, with_cfg: 1'b0, exp_busy: 1'b0};
        tv[3] = '{nload: 0, nw: 16'd2, with_cfg: 1'b1, exp_busy: 1'b0};
        tv[4] = '{nload: 8, nw: 16'd1, with_cfg: 1'b0, exp_busy: 1'b1};

        ones_w = {NW{16'h3C00}};
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; start = 1'b0; num_win = '0;
        win_valid = 1'b0; win_data = '0; res_ready = 1'b0;
        clear_stats();

        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_win_ready", win_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_pe_param", pe_param, 0);
        check("rst_pe_data", pe_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        #1;
        check("post_rst_cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;

        // Start acceptance table: partial load, zero windows, same-cycle cfg write
        for (int r = 0; r < 5; r++) begin
            write_weights(tv[r].nload);
            try_start(tv[r].nw, tv[r].with_cfg);
            check("start_busy", busy, tv[r].exp_busy);
            check("start_win_ready", win_ready, tv[r].exp_busy);
        end
        check("pe_param_loaded", pe_param, ones_w);

        // Single window of all 1.0: latency, 9.0 result, frame_done after the pop
        win_data = ones_w; win_valid = 1'b1; acc_edge = -1;
        for (int k = 0; k < 20 && acc_edge < 0; k++) begin
            @(negedge clk);
            if (win_ready) acc_edge = cyc + 1;
            @(posedge clk); #1;
        end
        win_valid = 1'b0;
        check("t1_accepted", acc_edge >= 0, 1);
        check("t1_pe_data", pe_data, ones_w);
        rv_cyc = -1;
        for (int k = 0; k < 40 && rv_cyc < 0; k++) begin
            @(negedge clk);
            if (res_valid) rv_cyc = cyc;
        end
        check("t1_latency", rv_cyc - acc_edge, PL);
        check("t1_res_data", res_data, 16'h4880);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("t1_frame_done", frame_done, 1);
        @(posedge clk); #1;
        check("t1_frame_done_pulse", frame_done, 0);
        check("t1_idle", busy, 0);
        check("t1_fd_count", fd_count, 1);

        // res_ready held low: credit limits accepts to FIFO_DEPTH
        clear_stats();
        try_start(16'd20, 1'b0);
        check("t3_busy", busy, 1);
        drive_frame(20, 30, 1'b0, 400, acc_hold, wr_hold, done);
        check("t3_done", done, 1);
        check("t3_acc_hold", acc_hold, FD);
        check("t3_win_ready_hold", wr_hold, 0);
        check("t3_pops", pop_count, 20);
        check("t3_fd_count", fd_count, 1);
        check("t3_sb_empty", exp_q.size(), 0);

        // Continuous stream: one accept per cycle, results without gaps
        clear_stats();
        try_start(16'd16, 1'b0);
        drive_frame(16, 0, 1'b0, 200, acc_hold, wr_hold, done);
        check("t4_done", done, 1);
        check("t4_accept_span", last_acc - first_acc, 15);
        check("t4_result_span", last_pop - first_pop, 15);
        check("t4_pops", pop_count, 16);
        check("t4_fd_count", fd_count, 1);

        // Random backpressure over 100 windows
        clear_stats();
        try_start(16'd100, 1'b0);
        drive_frame(100, 0, 1'b1, 3000, acc_hold, wr_hold, done);
        check("t5_done", done, 1);
        check("t5_pops", pop_count, 100);
        check("t5_max_occ", max_occ <= FD, 1);
        check("t5_fd_count", fd_count, 1);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset mid-frame with 3 windows in flight and 2 results queued
        clear_stats();
        try_start(16'd10, 1'b0);
        res_ready = 1'b0; win_valid = 1'b1; win_data = make_win(tag); n5 = 0;
        for (int k = 0; k < 30 && n5 < 5; k++) begin
            @(negedge clk);
            hs = win_valid && win_ready;
            @(posedge clk); #1;
            if (hs) begin n5++; tag++; win_data = make_win(tag); end
        end
        win_valid = 1'b0;
        check("t6_accepts", n5, 5);
        repeat (3) @(posedge clk);
        #1;
        check("t6_queued", res_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_res_valid", res_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cfg_ready", cfg_ready, 0);
        check("t6_rst_pe_param", pe_param, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        try_start(16'd1, 1'b0);
        check("t6_params_cleared", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_res_valid", res_valid, 0);
        check("t6_no_frame_done", fd_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
